regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised general-purpose register file for the pipelined MIPS I core. It provides a configurable number of asynchronous read ports, one synchronous write port, an optional write-to-read bypass and a hardwired-zero register 0. A per-register pending-write scoreboard lets the decode stage detect read-after-write hazards on in-flight loads and results. It sits between decode (reads, reserve, stall) and writeback (write, clear).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
- ZERO_REG, 1, 1 = register 0 reads as 0, is never written and is never pending

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rd_num_i  in  NUM_RD*ADDR_W  read indices; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_use_i  in  NUM_RD  port k operand actually consumed this cycle
- rd_data_o  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- rd_busy_o  out  NUM_RD  port k register has an outstanding write
- stall_o  out  1  OR over k of (rd_busy_o[k] & rd_use_i[k])
- wr_en_i  in  1  write strobe
- wr_num_i  in  ADDR_W  write index
- wr_data_i  in  DATA_W  write data
- rsv_en_i  in  1  mark rsv_num_i pending (instruction issued with that destination)
- rsv_num_i  in  ADDR_W  destination index to reserve
- flush_i  in  1  clear all pending bits (pipeline flush)
- pend_cnt_o  out  ADDR_W+1  number of registers currently pending

## Operation
- Storage: 2**ADDR_W x DATA_W array plus a pending bit vector of the same depth.
- Reset (rst=1 at edge): every register is 0, every pending bit is 0, and pend_cnt_o is 0. All other inputs are ignored that cycle. Reset overrides an in-progress write or reserve.
- Write: if wr_en_i is 1 and not (ZERO_REG and wr_num_i==0), then reg[wr_num_i] <= wr_data_i and the pending bit for wr_num_i clears.
- Reserve: if rsv_en_i is 1 and not (ZERO_REG and rsv_num_i==0), the pending bit for rsv_num_i sets.
- Write and reserve to the same index in the same cycle: data is written and the pending bit ends up 1 (the new producer wins).
- Reserving an already pending register leaves it at 1. Writing a non-pending register is legal and leaves the bit at 0.
- Flush: all pending bits become 0, and a simultaneous reserve is dropped. A simultaneous write still updates the data.
- Priority per pending bit: rst > flush > reserve > write-clear.
- Read port k, index r:
  - If ZERO_REG and r==0: data is 0 and busy is 0.
  - Else if BYPASS and wr_en_i and wr_num_i==r: data is wr_data_i and busy is 0.
  - Else: data is reg[r] and busy is pending[r].
- Ports with rd_use_i=0 still drive data and busy, but do not contribute to stall_o.
- pend_cnt_o is the population count of the registered pending vector. It is registered and updated at the same edge as the pending bits. Range is 0..2**ADDR_W (0..31 when ZERO_REG).

## Timing
- Reads, rd_busy_o and stall_o are combinational from rd_num_i, rd_use_i, the bypass inputs and state. They carry no clock latency.
- A write takes effect at the next rising edge. With BYPASS=1 it is also visible combinationally in the same cycle. With BYPASS=0 it is first visible the cycle after the edge.
- A reserve issued in cycle n makes rd_busy_o high from cycle n+1.
- A write in cycle m clears busy from cycle m+1, or in cycle m itself via bypass when BYPASS=1.
- pend_cnt_o lags the pending-bit update by 0 cycles: both are registered at the same edge.
- No handshake. The decode stage must hold its instruction while stall_o=1 and must not reserve while stalled.

## Test plan
- Reset: preload r5=0xDEADBEEF with r5 pending, then assert rst for 1 cycle -> all rd_data_o = 0, rd_busy_o = 0, pend_cnt_o = 0.
- Zero register: write r0=0x12345678 and reserve r0 -> reading r0 on all ports returns 0, busy 0, pend_cnt_o unchanged.
- Scoreboard: reserve r7 in cycle 1 -> from cycle 2, rd_busy_o=1 on the port reading r7, stall_o=1 when rd_use_i=1 and 0 when rd_use_i=0, pend_cnt_o=1. Write r7=0xA5A5A5A5 in cycle 4 -> with BYPASS=1, data 0xA5A5A5A5 and busy 0 in cycle 4; pend_cnt_o=0 in cycle 5.
- Same-cycle collision: write r9=0x11 and reserve r9 together -> next cycle r9 reads 0x11 with busy=1. Separately, write r9=0x22 with BYPASS=0 -> the old value is read in that cycle and 0x22 the next.
- Flush: reserve r3, r4 and r6 (pend_cnt_o=3), then assert flush_i together with rsv r10 and a write of r3=0x33 -> next cycle all busy 0, pend_cnt_o=0, r3=0x33.
- Multi-port: with NUM_RD=4, read r1, r2, r1 and r31 after writing distinct values -> each port returns its own value, and duplicate indices return identical data.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// GPR file with async read ports, one sync write port, optional bypass and a pending-write scoreboard.
// Latency: reads/busy/stall combinational; write, reserve and flush take effect at the next rising edge.
// Backpressure: no handshake; stall_o tells decode to hold while a consumed operand is still pending.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_num_i,
    input  logic [NUM_RD-1:0]        rd_use_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    output logic                     stall_o,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_num_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rsv_en_i,
    input  logic [ADDR_W-1:0]        rsv_num_i,
    input  logic                     flush_i,
    output logic [ADDR_W:0]          pend_cnt_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [CNT_W-1:0]  pend_cnt_q, pend_cnt_d;
    logic              wr_ok, rsv_ok;

    assign wr_ok  = wr_en_i  && !((ZERO_REG != 0) && (wr_num_i  == '0));
    assign rsv_ok = rsv_en_i && !((ZERO_REG != 0) && (rsv_num_i == '0));

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[wr_num_i] = wr_data_i;
        end
    end

    // Later assignments win: flush over reserve over write-clear.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok) begin
            pend_d[wr_num_i] = 1'b0;
        end
        if (rsv_ok) begin
            pend_d[rsv_num_i] = 1'b1;
        end
        if (flush_i) begin
            pend_d = '0;
        end
        pend_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_cnt_d = pend_cnt_d + CNT_W'(pend_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic              zero_hit;
        logic              byp_hit;

        assign idx      = rd_num_i[k*ADDR_W +: ADDR_W];
        assign zero_hit = (ZERO_REG != 0) && (idx == '0);
        assign byp_hit  = (BYPASS != 0) && wr_en_i && (wr_num_i == idx);

        assign rd_data_o[k*DATA_W +: DATA_W] = zero_hit ? '0 :
                                               byp_hit  ? wr_data_i : regs_q[idx];
        assign rd_busy_o[k] = !zero_hit && !byp_hit && pend_q[idx];
    end

    assign stall_o    = |(rd_busy_o & rd_use_i);
    assign pend_cnt_o = pend_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: dut_a is 4-port with bypass, dut_b is 2-port without bypass; both share write/reserve/flush.
module tb_regfile_scoreboard;

    localparam int DA  = 0;   // dut_a data ports 0..3
    localparam int BA  = 4;   // dut_a busy ports 4..7
    localparam int STA = 8;
    localparam int PA  = 9;
    localparam int DB  = 10;  // dut_b data ports 10..11
    localparam int BB  = 12;  // dut_b busy ports 12..13
    localparam int STB = 14;
    localparam int PB  = 15;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [19:0]  rd_num_a;
    logic [3:0]   rd_use_a;
    logic [127:0] rd_data_a;
    logic [3:0]   rd_busy_a;
    logic         stall_a;
    logic [5:0]   pend_a;
    logic [9:0]   rd_num_b;
    logic [1:0]   rd_use_b;
    logic [63:0]  rd_data_b;
    logic [1:0]   rd_busy_b;
    logic         stall_b;
    logic [5:0]   pend_b;
    logic         wr_en;
    logic [4:0]   wr_num;
    logic [31:0]  wr_data;
    logic         rsv_en;
    logic [4:0]   rsv_num;
    logic         flush;

    exp_t exp_q[$];
    logic sample = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .rd_num_i(rd_num_a), .rd_use_i(rd_use_a),
        .rd_data_o(rd_data_a), .rd_busy_o(rd_busy_a), .stall_o(stall_a),
        .wr_en_i(wr_en), .wr_num_i(wr_num), .wr_data_i(wr_data),
        .rsv_en_i(rsv_en), .rsv_num_i(rsv_num), .flush_i(flush), .pend_cnt_o(pend_a)
    );

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst(rst), .rd_num_i(rd_num_b), .rd_use_i(rd_use_b),
        .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b), .stall_o(stall_b),
        .wr_en_i(wr_en), .wr_num_i(wr_num), .wr_data_i(wr_data),
        .rsv_en_i(rsv_en), .rsv_num_i(rsv_num), .flush_i(flush), .pend_cnt_o(pend_b)
    );

    function automatic logic [31:0] actual(input int sel);
        if (sel < BA)       return rd_data_a[(sel-DA)*32 +: 32];
        else if (sel < STA) return {31'b0, rd_busy_a[sel-BA]};
        else if (sel == STA) return {31'b0, stall_a};
        else if (sel == PA)  return {26'b0, pend_a};
        else if (sel < BB)  return rd_data_b[(sel-DB)*32 +: 32];
        else if (sel < STB) return {31'b0, rd_busy_b[sel-BB]};
        else if (sel == STB) return {31'b0, stall_b};
        else                return {26'b0, pend_b};
    endfunction

    // Monitor: on the falling edge of each flagged cycle, pop and compare everything queued for it.
    always @(negedge clk) begin
        if (sample) begin
            while (exp_q.size() > 0) begin
                exp_t        e;
                logic [31:0] a;
                e = exp_q.pop_front();
                a = actual(e.sel);
                n_checks++;
                if (a === e.val) n_pass++;
                else $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.val);
            end
        end
    end

    task automatic expect_v(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        exp_q.push_back(e);
        sample = 1'b1;
    endtask

    // Advance one cycle; inputs for the new cycle are idle until the caller drives them.
    task automatic step();
        @(posedge clk);
        #1;
        sample  = 1'b0;
        wr_en   = 1'b0;
        rsv_en  = 1'b0;
        flush   = 1'b0;
        rd_use_a = 4'b0;
        rd_use_b = 2'b0;
    endtask

    task automatic rd_a(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
        rd_num_a = {a3, a2, a1, a0};
    endtask

    task automatic rd_b(input logic [4:0] b0, input logic [4:0] b1);
        rd_num_b = {b1, b0};
    endtask

    task automatic wr(input logic [4:0] n, input logic [31:0] d);
        wr_en = 1'b1; wr_num = n; wr_data = d;
    endtask

    task automatic rsv(input logic [4:0] n);
        rsv_en = 1'b1; rsv_num = n;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; wr_en = 0; wr_num = 0; wr_data = 0; rsv_en = 0; rsv_num = 0; flush = 0;
        rd_num_a = '0; rd_use_a = '0; rd_num_b = '0; rd_use_b = '0;
        step(); step();
        rst = 1'b0;

        // Reset: preload r5 with pending, then reset while a write and reserve are also asserted
        wr(5'd5, 32'hDEADBEEF); rsv(5'd5);
        step();
        rd_a(5'd5, 5'd6, 5'd8, 5'd5); rd_b(5'd5, 5'd6);
        expect_v("preload_r5", DA+0, 32'hDEADBEEF);
        expect_v("preload_busy", BA+0, 1);
        expect_v("preload_cnt", PA, 1);
        rst = 1'b1; wr(5'd6, 32'h66); rsv(5'd8);
        step();
        rst = 1'b0;
        expect_v("rst_r5", DA+0, 0);
        expect_v("rst_r6", DA+1, 0);
        expect_v("rst_busy_r5", BA+0, 0);
        expect_v("rst_busy_r8", BA+2, 0);
        expect_v("rst_cnt_a", PA, 0);
        expect_v("rst_b_r5", DB+0, 0);
        expect_v("rst_cnt_b", PB, 0);

        // Zero register: write and reserve r0
        step();
        rd_a(5'd0, 5'd0, 5'd0, 5'd0); rd_b(5'd0, 5'd0);
        wr(5'd0, 32'h12345678); rsv(5'd0);
        expect_v("r0_byp_data", DA+0, 0);
        expect_v("r0_byp_busy", BA+3, 0);
        step();
        expect_v("r0_data_p1", DA+1, 0);
        expect_v("r0_data_p3", DA+3, 0);
        expect_v("r0_busy_p2", BA+2, 0);
        expect_v("r0_cnt", PA, 0);
        expect_v("r0_b_data", DB+1, 0);

        // Scoreboard: reserve r7 then write it
        step();
        rsv(5'd7);
        step();
        rd_a(5'd7, 5'd0, 5'd0, 5'd0); rd_b(5'd7, 5'd0);
        rd_use_a = 4'b0001; rd_use_b = 2'b01;
        expect_v("r7_busy", BA+0, 1);
        expect_v("r7_stall_use", STA, 1);
        expect_v("r7_cnt", PA, 1);
        step();
        expect_v("r7_busy_nouse", BA+0, 1);
        expect_v("r7_stall_nouse", STA, 0);
        step();
        rd_use_a = 4'b0001; rd_use_b = 2'b01;
        wr(5'd7, 32'hA5A5A5A5);
        expect_v("r7_byp_data", DA+0, 32'hA5A5A5A5);
        expect_v("r7_byp_busy", BA+0, 0);
        expect_v("r7_byp_stall", STA, 0);
        expect_v("r7_cnt_wr_cycle", PA, 1);
        expect_v("r7_nobyp_old", DB+0, 0);
        expect_v("r7_nobyp_busy", BB+0, 1);
        expect_v("r7_nobyp_stall", STB, 1);
        step();
        expect_v("r7_cnt_after", PA, 0);
        expect_v("r7_data_after", DA+0, 32'hA5A5A5A5);
        expect_v("r7_b_data_after", DB+0, 32'hA5A5A5A5);
        expect_v("r7_b_busy_after", BB+0, 0);

        // Same-cycle write and reserve: new producer wins the pending bit
        step();
        wr(5'd9, 32'h11); rsv(5'd9);
        step();
        rd_a(5'd9, 5'd0, 5'd0, 5'd0); rd_b(5'd9, 5'd0);
        expect_v("r9_coll_data", DA+0, 32'h11);
        expect_v("r9_coll_busy", BA+0, 1);
        expect_v("r9_coll_cnt", PA, 1);
        step();
        wr(5'd9, 32'h22);
        expect_v("r9_byp_new", DA+0, 32'h22);
        expect_v("r9_nobyp_old", DB+0, 32'h11);
        expect_v("r9_nobyp_busy", BB+0, 1);
        step();
        expect_v("r9_nobyp_new", DB+0, 32'h22);
        expect_v("r9_nobyp_busy_clr", BB+0, 0);
        expect_v("r9_cnt_clr", PB, 0);

        // Flush drops pending bits and a simultaneous reserve, but keeps the write
        step(); rsv(5'd3);
        step(); rsv(5'd4);
        step(); rsv(5'd6);
        step();
        rd_a(5'd3, 5'd4, 5'd6, 5'd10); rd_b(5'd3, 5'd10);
        expect_v("flush_pre_cnt", PA, 3);
        expect_v("flush_pre_busy_r4", BA+1, 1);
        flush = 1'b1; rsv(5'd10); wr(5'd3, 32'h33);
        step();
        expect_v("flush_busy_r3", BA+0, 0);
        expect_v("flush_busy_r4", BA+1, 0);
        expect_v("flush_busy_r6", BA+2, 0);
        expect_v("flush_busy_r10", BA+3, 0);
        expect_v("flush_cnt_a", PA, 0);
        expect_v("flush_cnt_b", PB, 0);
        expect_v("flush_r3_data", DB+0, 32'h33);

        // Multi-port reads with duplicate indices
        step(); wr(5'd1, 32'h11110001);
        step(); wr(5'd2, 32'h22220002);
        step(); wr(5'd31, 32'h31313131);
        step();
        rd_a(5'd1, 5'd2, 5'd1, 5'd31); rd_b(5'd2, 5'd31);
        expect_v("mp_p0_r1", DA+0, 32'h11110001);
        expect_v("mp_p1_r2", DA+1, 32'h22220002);
        expect_v("mp_p2_r1", DA+2, 32'h11110001);
        expect_v("mp_p3_r31", DA+3, 32'h31313131);
        expect_v("mp_b_r2", DB+0, 32'h22220002);
        expect_v("mp_b_r31", DB+1, 32'h31313131);

        step();
        step();
        if (exp_q.size() != 0) begin
            $display("FAIL drain: got %0d unchecked expected 0", exp_q.size());
            n_checks += exp_q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
